// File: rtl/spi_dac_tx.sv
// ---------------------------------------------------------------------------
// spi_dac_tx
//
// SPI transmitter for the MCP4911 10-bit DAC on the output side of the audio
// path. A 10-bit sample is taken over a load/ready handshake into a one-deep
// holding buffer. It is then sent as a 16-bit command word, MSB first:
//   {A/B=0, BUF=VREF_BUF, GA_n=GAIN_1X, SHDN_n=1, sample[9:0], 2'b00}
// CS, SCK and SDI are generated from sysclk by a free-running tick divider.
// One SCK period lasts two ticks.
//
// Parameters
//   CLK_DIV   tick every CLK_DIV+1 sysclk cycles
//   GAIN_1X   value sent on command bit 13 (1 = 1x gain)
//   VREF_BUF  value sent on command bit 14
//
// Ports
//   sysclk    in   system clock
//   reset     in   synchronous, active-high reset
//   load      in   sample strobe, accepted only while ready=1
//   data_in   in   10-bit sample, captured on an accepted load
//   ready     out  holding buffer empty
//   busy      out  frame in progress
//   overrun   out  one-cycle pulse when load arrives while ready=0
//   dac_cs    out  chip select, active low
//   dac_sck   out  SPI clock, idles low, DAC samples on the rising edge
//   dac_sdi   out  serial data, changes on SCK fall / CS fall
//   dac_ldac  out  DAC latch strobe, active low
//
// Build option
//   SPI_DAC_LDAC_EN  when defined, dac_ldac pulses low for one tick period.
//                    The pulse starts one tick after CS rises. When the macro
//                    is not defined, dac_ldac is tied low and the DAC updates
//                    on CS rise.
// ---------------------------------------------------------------------------
module spi_dac_tx #(
  parameter logic [4:0] CLK_DIV  = 5'd24,
  parameter logic       GAIN_1X  = 1'b1,
  parameter logic       VREF_BUF = 1'b0
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] data_in,
  output logic       ready,
  output logic       busy,
  output logic       overrun,
  output logic       dac_cs,
  output logic       dac_sck,
  output logic       dac_sdi,
  output logic       dac_ldac
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ctr_q, ctr_d;
  logic        tick_q, tick_d;
  logic [9:0]  hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        ready_q, ready_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
`ifdef SPI_DAC_LDAC_EN
  logic        ldac_q, ldac_d;
`endif

  // Next-state logic for the tick divider, the holding buffer and the frame
  // FSM. Every register holds its value unless a branch below changes it. The
  // FSM moves only on tick_q. The buffer handshake runs every cycle, so the
  // next sample can be loaded while the current frame is still shifting out.
  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    tick_d       = 1'b0;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d    = 1'b0;
    cs_d         = cs_q;
    sck_d        = sck_q;
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
`ifdef SPI_DAC_LDAC_EN
    ldac_d       = ldac_q;
`endif

    // The counter reloads on zero, and tick is the registered zero detect.
    if (ctr_q == 5'd0) begin
      ctr_d  = CLK_DIV;
      tick_d = 1'b1;
    end else begin
      ctr_d  = ctr_q - 5'd1;
    end

    // A load is judged against the registered ready flag. In the cycle where
    // IDLE consumes the buffer, ready is still 0, so that load is dropped.
    if (load && ready_q) begin
      hold_d       = data_in;
      hold_valid_d = 1'b1;
    end else if (load) begin
      overrun_d    = 1'b1;
    end

    if (tick_q) begin
      case (state_q)
        S_IDLE: begin
          if (hold_valid_q) begin
            shift_d      = {1'b0, VREF_BUF, GAIN_1X, 1'b1, hold_q, 2'b00};
            hold_valid_d = 1'b0;
            cs_d         = 1'b0;
            bitcnt_d     = 4'd15;
            state_d      = S_SETUP;
          end
        end
        S_SETUP: begin
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          // Rising ticks only raise SCK. Falling ticks advance the data.
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            shift_d = {shift_q[14:0], 1'b0};
            if (bitcnt_q == 4'd0) begin
              state_d = S_HOLD;
            end else begin
              bitcnt_d = bitcnt_q - 4'd1;
            end
          end
        end
        S_HOLD: begin
          cs_d    = 1'b1;
          state_d = S_GAP;
        end
        S_GAP: begin
          state_d = S_IDLE;
        end
        default: begin
          cs_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase

`ifdef SPI_DAC_LDAC_EN
      // LDAC goes low on the tick that leaves GAP and returns high on the next
      // tick. This keeps the strobe clear of the CS rising edge.
      ldac_d = (state_q == S_GAP) ? 1'b0 : 1'b1;
`endif
    end

    if (state_d != S_SHIFT) begin
      sck_d = 1'b0;
    end

    sdi_d   = cs_d ? 1'b0 : shift_d[15];
    ready_d = !hold_valid_d;
    busy_d  = (state_d != S_IDLE);
  end

  // All state and every output is registered here. Reset is synchronous and
  // has priority over everything else. A reset mid-frame raises CS on the
  // next edge and throws the partial word away.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ctr_q        <= CLK_DIV;
      tick_q       <= 1'b0;
      hold_q       <= 10'd0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      cs_q         <= 1'b1;
      sck_q        <= 1'b0;
      sdi_q        <= 1'b0;
      shift_q      <= 16'd0;
      bitcnt_q     <= 4'd0;
`ifdef SPI_DAC_LDAC_EN
      ldac_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      tick_q       <= tick_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      cs_q         <= cs_d;
      sck_q        <= sck_d;
      sdi_q        <= sdi_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
`ifdef SPI_DAC_LDAC_EN
      ldac_q       <= ldac_d;
`endif
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
  assign dac_cs  = cs_q;
  assign dac_sck = sck_q;
  assign dac_sdi = sdi_q;
`ifdef SPI_DAC_LDAC_EN
  assign dac_ldac = ldac_q;
`else
  assign dac_ldac = 1'b0;
`endif

endmodule
